pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register. It replaces the hand-enumerated per-signal inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a packed control field and a packed data field, plus a valid bit.
- Supports stall via ready/valid backpressure, flush (bubble insertion), and an optional one-entry skid buffer so that in_ready is fully registered.
- Instantiated once per pipeline boundary in the processor.

Parameters:
- CTRL_W, 24, width of packed control field (reg_write_en, mem_write, mem_read, halt, err, etc.); forced to NOP_CTRL on a bubble.
- DATA_W, 96, width of packed data field (operands, immediates, pc_inc, pc_new); not cleared on a bubble.
- NOP_CTRL, {CTRL_W{1'b0}}, control value presented whenever the stage holds no valid instruction.
- SKID, 1, 1 = one-entry skid buffer with registered in_ready; 0 = in_ready combinational from out_ready.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control
- in_data  in  DATA_W  upstream data
- flush  in  1  squash all held and incoming contents (branch mispredict / exception)
- out_valid  out  1  stage holds a valid instruction
- out_ready  in  1  downstream accepts; low = stall
- out_ctrl  out  CTRL_W  registered control (NOP_CTRL when !out_valid)
- out_data  out  DATA_W  registered data

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_ctrl=NOP_CTRL, out_data=0, skid empty. in_ready=1 in the cycle after reset.
- Priority each edge: rst > flush > normal transfer.
- Flush: out_valid=0, out_ctrl=NOP_CTRL, skid emptied, in_valid that cycle dropped. out_data holds its old value. in_ready=1 on the next cycle.
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle from in_fire to out_valid when the main register is empty or draining. Full throughput: 1 instruction per cycle while out_ready=1.
- SKID=1, states EMPTY, MAIN, FULL (main + skid occupied):
  - EMPTY: in_fire -> MAIN.
  - MAIN:
    - in_fire & out_fire -> MAIN (main reloaded).
    - in_fire & !out_fire -> FULL (incoming word captured in skid).
    - !in_fire & out_fire -> EMPTY.
  - FULL: in_ready=0. out_fire -> MAIN; skid moves into main the same edge.
  - in_ready is registered and equals (state != FULL).
- SKID=0:
  - in_ready = out_ready | !out_valid (combinational).
  - Main register loads on in_fire, clears valid on out_fire without in_fire, holds otherwise.
- Bubble rule: whenever out_valid=0, out_ctrl must equal NOP_CTRL. This applies to every path: reset, flush, drain, and in_valid=0 load.
- Stall hold: while out_valid & !out_ready, out_ctrl and out_data must stay stable.
- Simultaneous flush & out_fire: flush wins. The downstream consumes the word present before the edge; the stage is empty after the edge.
- Reset asserted mid-stall in FULL discards both entries.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds two output ports:
  - stall_cnt[15:0]: increments each cycle with out_valid & !out_ready.
  - bubble_cnt[15:0]: increments each cycle out_valid=0 without rst.
  - Both saturate at 16'hFFFF and clear on rst only (not on flush).
- When undefined, the ports and counters are absent. Stage behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - skid state typedef (EMPTY/MAIN/FULL) and its encoding;
  - per-boundary CTRL_W/DATA_W constants (ID_EX_CTRL_W, ID_EX_DATA_W, ...);
  - per-boundary NOP_CTRL constants.
- One natural sub-module: pipe_skid_slot, a single valid/ctrl/data holding register with load/clear. It is instantiated twice: main and skid.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_ctrl=24'hABCDEF -> out_valid=0, out_ctrl=0, in_ready=1 the cycle after rst falls.
- Streaming: 8 back-to-back words, in_data=k (k=0..7), out_ready=1 -> out_data=k exactly one cycle after each in_fire, no gaps.
- Stall, SKID=1:
  - Setup: word A in main; drop out_ready for 3 cycles while driving word B then word C.
  - Expected: B captured in skid; in_ready=0; C held upstream; out_data=A stable.
  - Raise out_ready: outputs A, B, C in order, nothing lost or duplicated.
- Flush in FULL state: flush=1 together with in_valid=1 -> next cycle out_valid=0, out_ctrl=NOP_CTRL, in_ready=1; the flushed input never appears at out_*.
- Bubble: in_valid=0 for 2 cycles inside a stream -> out_valid=0 and out_ctrl=NOP_CTRL for exactly 2 cycles; out_data unchecked.
- PIPE_STAGE_PERF_EN:
  - 5 stall cycles then flush -> stall_cnt=5; bubble_cnt counts the post-flush empty cycles; neither counter is cleared by flush.
  - Force stall_cnt near 16'hFFFF -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline-boundary types and per-boundary widths/NOP values.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MAIN  = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_t;

    localparam int IF_ID_CTRL_W  = 8;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 24;
    localparam int ID_EX_DATA_W  = 96;
    localparam int EX_MEM_CTRL_W = 16;
    localparam int EX_MEM_DATA_W = 96;
    localparam int MEM_WB_CTRL_W = 8;
    localparam int MEM_WB_DATA_W = 64;

    localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_NOP_CTRL  = '0;
    localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_NOP_CTRL  = '0;
    localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_NOP_CTRL = '0;
    localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_NOP_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_slot
// Brief    : One valid/ctrl/data holding register; clear beats load.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 24,
    parameter int                DATA_W   = 96,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Data is deliberately left alone on clear; only control is bubbled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= NOP_CTRL;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= NOP_CTRL;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Ready/valid pipeline stage register with flush and optional skid.
//            Define PIPE_STAGE_PERF_EN to add stall/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 24,
    parameter int                DATA_W   = 96,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}},
    parameter int                SKID     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`endif
);

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_clear;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_d;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    pipe_skid_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .NOP_CTRL (NOP_CTRL)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ctrl_d),
        .i_data  (w_main_data_d),
        .o_valid (out_valid),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            skid_state_t       r_state;
            skid_state_t       w_state_nxt;
            logic              r_in_ready;
            logic              w_skid_load;
            logic              w_skid_clear;
            logic              w_skid_valid;
            logic [CTRL_W-1:0] w_skid_ctrl;
            logic [DATA_W-1:0] w_skid_data;

            pipe_skid_slot #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .NOP_CTRL (NOP_CTRL)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );

            // in_ready comes straight from a flop so upstream sees no comb path.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end

            always_comb begin
                w_state_nxt   = r_state;
                w_main_load   = 1'b0;
                w_main_clear  = flush;
                w_main_ctrl_d = in_ctrl;
                w_main_data_d = in_data;
                w_skid_load   = 1'b0;
                w_skid_clear  = flush;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_in_fire) begin
                            w_main_load = 1'b1;
                            w_state_nxt = ST_MAIN;
                        end
                    end
                    ST_MAIN: begin
                        if (w_in_fire && w_out_fire) begin
                            w_main_load = 1'b1;
                        end else if (w_in_fire) begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_FULL;
                        end else if (w_out_fire) begin
                            w_main_clear = 1'b1;
                            w_state_nxt  = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (w_out_fire) begin
                            w_main_load   = w_skid_valid;
                            w_main_ctrl_d = w_skid_ctrl;
                            w_main_data_d = w_skid_data;
                            w_skid_clear  = 1'b1;
                            w_state_nxt   = ST_MAIN;
                        end
                    end
                    default: w_state_nxt = ST_EMPTY;
                endcase
            end

            assign in_ready = r_in_ready;
        end else begin : g_direct
            assign in_ready = out_ready | ~out_valid;

            always_comb begin
                w_main_load   = w_in_fire;
                w_main_clear  = flush | (w_out_fire & ~w_in_fire);
                w_main_ctrl_d = in_ctrl;
                w_main_data_d = in_data;
            end
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= 16'h0000;
            r_bubble_cnt <= 16'h0000;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            if (!out_valid && (r_bubble_cnt != 16'hFFFF))
                r_bubble_cnt <= r_bubble_cnt + 16'h0001;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench: SKID=1 and SKID=0 stages against queue models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CTRL_W = 24;
    localparam int DATA_W = 96;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;

    logic              in_ready1, out_valid1, in_ready0, out_valid0;
    logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
    logic [DATA_W-1:0] out_data1, out_data0;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt1, bubble_cnt1, stall_cnt0, bubble_cnt0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    word_t q1[$];
    word_t q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1)
`endif
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
`endif
    );

    // Stage modelled as a FIFO: capacity 2 with skid, 1 without.
    task automatic tick();
        bit    fi1, fo1, fi0, fo0;
        word_t w;
        w.c = in_ctrl;
        w.d = in_data;
        fi1 = in_valid && (q1.size() < 2);
        fo1 = (q1.size() > 0) && out_ready;
        fi0 = in_valid && (out_ready || (q0.size() == 0));
        fo0 = (q0.size() > 0) && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (fo1) void'(q1.pop_front());
            if (fi1) q1.push_back(w);
            if (fo0) void'(q0.pop_front());
            if (fi0) q0.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 24'hABCDEF, 96'h1234);
        tick();
        tick();
        n_checks++;
        if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid1); end
        n_checks++;
        if (out_ctrl1 !== 24'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 000000", out_ctrl1); end
        n_checks++;
        if (out_data1 !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data1); end
        rst = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        n_checks++;
        if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready1); end
        n_checks++;
        if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_valid: got %b/%b want 0/0", out_valid1, out_valid0);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, CTRL_W'(k + 1), DATA_W'(k));
            n_checks++;
            if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL stream_ready k=%0d: got %b want 1", k, in_ready1); end
            tick();
            n_checks++;
            if (out_valid1 !== 1'b1 || out_data1 !== DATA_W'(k) || out_ctrl1 !== CTRL_W'(k + 1)) begin
                n_fail++; $display("FAIL stream_skid k=%0d: got v=%b d=%0h want v=1 d=%0h", k, out_valid1, out_data1, k);
            end
            n_checks++;
            if (out_valid0 !== 1'b1 || out_data0 !== DATA_W'(k)) begin
                n_fail++; $display("FAIL stream_direct k=%0d: got v=%b d=%0h want v=1 d=%0h", k, out_valid0, out_data0, k);
            end
        end
        drive(1'b0, '0, '0);
        tick();
        n_checks++;
        if (out_valid1 !== 1'b0 || out_ctrl1 !== 24'h0) begin
            n_fail++; $display("FAIL stream_drain: got v=%b c=%h want v=0 c=0", out_valid1, out_ctrl1);
        end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b1;
        drive(1'b1, 24'h00000A, 96'hA);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 24'h00000B, 96'hB);
        n_checks++;
        if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL stall_ready_main: got %b want 1", in_ready1); end
        tick();
        drive(1'b1, 24'h00000C, 96'hC);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid1 !== 1'b1 || out_data1 !== 96'hA || out_ctrl1 !== 24'h00000A || in_ready1 !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold i=%0d: got v=%b d=%0h r=%b want v=1 d=a r=0", i, out_valid1, out_data1, in_ready1);
            end
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 96'hB || in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL stall_out_b: got v=%b d=%0h r=%b want v=1 d=b r=1", out_valid1, out_data1, in_ready1);
        end
        tick();
        n_checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== 96'hC) begin
            n_fail++; $display("FAIL stall_out_c: got v=%b d=%0h want v=1 d=c", out_valid1, out_data1);
        end
        drive(1'b0, '0, '0);
        tick();
        n_checks++;
        if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", out_valid1); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b1;
        drive(1'b1, 24'h0000A1, 96'hA1);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 24'h0000B1, 96'hB1);
        tick();
        n_checks++;
        if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL flush_setup_full: got ready %b want 0", in_ready1); end
        flush = 1'b1;
        drive(1'b1, 24'h0000F1, 96'hF1);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        n_checks++;
        if (out_valid1 !== 1'b0 || out_ctrl1 !== 24'h0 || in_ready1 !== 1'b1) begin
            n_fail++; $display("FAIL flush_state: got v=%b c=%h r=%b want v=0 c=0 r=1", out_valid1, out_ctrl1, in_ready1);
        end
        n_checks++;
        if (out_data1 !== 96'hA1) begin n_fail++; $display("FAIL flush_data_hold: got %0h want a1", out_data1); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin
                n_fail++; $display("FAIL flush_no_leak i=%0d: got v=%b/%b want 0/0", i, out_valid1, out_valid0);
            end
        end
    endtask

    task automatic test_bubble();
        logic [5:0] pat;
        pat = 6'b110011;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(pat[5-i], CTRL_W'(8'h40 + i), DATA_W'(i));
            tick();
            n_checks++;
            if (out_valid1 !== pat[5-i] || (!pat[5-i] && out_ctrl1 !== 24'h0)) begin
                n_fail++; $display("FAIL bubble_skid i=%0d: got v=%b c=%h want v=%b", i, out_valid1, out_ctrl1, pat[5-i]);
            end
            n_checks++;
            if (out_valid0 !== pat[5-i] || (!pat[5-i] && out_ctrl0 !== 24'h0)) begin
                n_fail++; $display("FAIL bubble_direct i=%0d: got v=%b c=%h want v=%b", i, out_valid0, out_ctrl0, pat[5-i]);
            end
        end
        drive(1'b0, '0, '0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, CTRL_W'($urandom) | CTRL_W'(1), {$urandom, $urandom, $urandom});
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            #1;
            n_checks++;
            if (in_ready1 !== (q1.size() < 2)) begin
                n_fail++; $display("FAIL rand_ready_skid i=%0d: got %b want %b", i, in_ready1, q1.size() < 2);
            end
            n_checks++;
            if (in_ready0 !== (out_ready || q0.size() == 0)) begin
                n_fail++; $display("FAIL rand_ready_direct i=%0d: got %b want %b", i, in_ready0, out_ready || q0.size() == 0);
            end
            tick();
            n_checks++;
            if (q1.size() == 0 ? (out_valid1 !== 1'b0 || out_ctrl1 !== 24'h0)
                               : (out_valid1 !== 1'b1 || out_ctrl1 !== q1[0].c || out_data1 !== q1[0].d)) begin
                n_fail++; $display("FAIL rand_out_skid i=%0d: got v=%b c=%h d=%h want n=%0d", i, out_valid1, out_ctrl1, out_data1, q1.size());
            end
            n_checks++;
            if (q0.size() == 0 ? (out_valid0 !== 1'b0 || out_ctrl0 !== 24'h0)
                               : (out_valid0 !== 1'b1 || out_ctrl0 !== q0[0].c || out_data0 !== q0[0].d)) begin
                n_fail++; $display("FAIL rand_out_direct i=%0d: got v=%b c=%h d=%h want n=%0d", i, out_valid0, out_ctrl0, out_data0, q0.size());
            end
        end
        flush = 1'b0;
        drive(1'b0, '0, '0);
        tick();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        rst = 1'b0;
        drive(1'b1, 24'h0000AA, 96'hAA);
        tick();
        drive(1'b0, '0, '0);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (stall_cnt1 !== 16'd5 || bubble_cnt1 !== 16'd1) begin
            n_fail++; $display("FAIL perf_after_flush: got s=%0d b=%0d want s=5 b=1", stall_cnt1, bubble_cnt1);
        end
        repeat (3) tick();
        n_checks++;
        if (stall_cnt1 !== 16'd5 || bubble_cnt1 !== 16'd4) begin
            n_fail++; $display("FAIL perf_bubbles: got s=%0d b=%0d want s=5 b=4", stall_cnt1, bubble_cnt1);
        end
        drive(1'b1, 24'h0000BB, 96'hBB);
        tick();
        drive(1'b0, '0, '0);
        repeat (65540) tick();
        n_checks++;
        if (stall_cnt1 !== 16'hFFFF || bubble_cnt1 !== 16'd5) begin
            n_fail++; $display("FAIL perf_saturate: got s=%h b=%0d want s=ffff b=5", stall_cnt1, bubble_cnt1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (stall_cnt1 !== 16'h0 || bubble_cnt1 !== 16'h0) begin
            n_fail++; $display("FAIL perf_reset: got s=%0d b=%0d want 0/0", stall_cnt1, bubble_cnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_full();
        test_bubble();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
